// File: rtl/fpu_arith_pkg.sv
// Shared arithmetic definitions for the FPU mantissa multiplier and divider chains:
// FSM state encoding, steps retired per compute cycle, and the ceil-div helper.
package fpu_arith_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned STEPS_PER_CYCLE = 4;

  function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/seq_mult4_if.sv
// Start/busy/done handshake and operand/product bus of the sequential multiplier.
interface seq_mult4_if #(
  parameter int unsigned INPUT_SIZE = 10
);
  logic                      start;
  logic [INPUT_SIZE-1:0]     A;
  logic [INPUT_SIZE-1:0]     B;
  logic                      busy;
  logic                      done;
  logic [2*INPUT_SIZE-1:0]   P;

  modport master (output start, output A, output B, input busy, input done, input P);
  modport slave  (input start, input A, input B, output busy, output done, output P);
endinterface

// File: rtl/seq_mult4_mulunit.sv
// One combinational add-shift step: conditionally add mcand into acc, then advance both
// the multiplicand (left) and multiplier (right) by one bit.
module mulunit
  import fpu_arith_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 10
) (
  input  logic [2*INPUT_SIZE-1:0]                              acc_i,
  input  logic [2*INPUT_SIZE-1:0]                              mcand_i,
  input  logic [STEPS_PER_CYCLE*ceil_div(INPUT_SIZE, STEPS_PER_CYCLE)-1:0] mplier_i,
  output logic [2*INPUT_SIZE-1:0]                              acc_o,
  output logic [2*INPUT_SIZE-1:0]                              mcand_o,
  output logic [STEPS_PER_CYCLE*ceil_div(INPUT_SIZE, STEPS_PER_CYCLE)-1:0] mplier_o
);

  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/seq_mult4.sv
// Sequential unsigned multiplier retiring four multiplier bits per cycle via a mulunit chain.
// Optional build macro EARLY_TERM_EN finishes as soon as the remaining multiplier is zero.
module seq_mult4
  import fpu_arith_pkg::*;
#(
  parameter int unsigned INPUT_SIZE = 10
) (
  input  logic         clk,
  input  logic         rst,
  seq_mult4_if.slave   bus
);

  localparam int unsigned ITER = ceil_div(INPUT_SIZE, STEPS_PER_CYCLE);
  localparam int unsigned PW   = 2 * INPUT_SIZE;
  localparam int unsigned MW   = STEPS_PER_CYCLE * ITER;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  state_e              state_q, state_d;
  logic [PW-1:0]       acc_q, acc_d;
  logic [PW-1:0]       mcand_q, mcand_d;
  logic [MW-1:0]       mplier_q, mplier_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]       p_q, p_d;

  logic [PW-1:0]       acc_c   [STEPS_PER_CYCLE+1];
  logic [PW-1:0]       mcand_c [STEPS_PER_CYCLE+1];
  logic [MW-1:0]       mplier_c[STEPS_PER_CYCLE+1];
  logic                last_cycle;

  assign acc_c[0]    = acc_q;
  assign mcand_c[0]  = mcand_q;
  assign mplier_c[0] = mplier_q;

  for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
    mulunit #(
      .INPUT_SIZE(INPUT_SIZE)
    ) u_step (
      .acc_i    (acc_c[g]),
      .mcand_i  (mcand_c[g]),
      .mplier_i (mplier_c[g]),
      .acc_o    (acc_c[g+1]),
      .mcand_o  (mcand_c[g+1]),
      .mplier_o (mplier_c[g+1])
    );
  end

`ifdef EARLY_TERM_EN
  assign last_cycle = (cnt_q == CntW'(ITER - 1)) || (mplier_c[STEPS_PER_CYCLE] == '0);
`else
  assign last_cycle = (cnt_q == CntW'(ITER - 1));
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = PW'(bus.A);
          mplier_d = MW'(bus.B);
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_c[STEPS_PER_CYCLE];
        mcand_d  = mcand_c[STEPS_PER_CYCLE];
        mplier_d = mplier_c[STEPS_PER_CYCLE];
        cnt_d    = cnt_q + 1'b1;
        if (last_cycle) begin
          p_d     = acc_c[STEPS_PER_CYCLE];
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.P    = p_q;

endmodule
